// File: rtl/ef_smsdac_pkg.sv
// Shared types and constants for the segmented mismatch-shaping DAC controller.
package ef_smsdac_pkg;

  // Controller phases: idle, warm-up (whitening), mismatch shaping, midscale mute
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2,
    ST_MUTE = 2'd3
  } smsdac_state_t;

  // Dither LFSR: seed and feedback taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Midscale code for a DAC of the given width (MSB set, rest clear)
  function automatic logic [31:0] midscale(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/ef_smsdac_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR supplying dither bits; reloads the seed on reset.
module ef_smsdac_lfsr16
  import ef_smsdac_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] lfsr
);

  logic feedback;

  assign feedback = ^(lfsr & LFSR_TAPS);

  // Shift right every clock, feeding the tap parity into the MSB
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {feedback, lfsr[15:1]};
    end
  end

endmodule

// File: rtl/ef_smsdac_ctrl.sv
// Sample-rate controller / scheduler for the segmented mismatch-shaping DAC encoder.
// Optional build macro SMSDAC_CTRL_UFLOW_CNT_EN adds a saturating underflow counter output.
module ef_smsdac_ctrl
  import ef_smsdac_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int NR       = 8,
  parameter int DIVW     = 8,
  parameter int WARM_SMP = 16,
  parameter int MUTE_SMP = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [DIVW-1:0] i_div,
  input  logic            i_shape_en,
  input  logic [BITS-1:0] i_code,
  input  logic            i_valid,
  output logic            o_ready,
  output logic [BITS-1:0] o_code,
  output logic [NR-1:0]   o_r,
  output logic            o_en,
  output logic            o_smp,
  output logic            o_busy,
  output logic            o_uflow,
  input  logic            i_uflow_clr
`ifdef SMSDAC_CTRL_UFLOW_CNT_EN
  ,
  output logic [7:0]      o_uflow_cnt
`endif
);

  localparam logic [31:0]     MID32    = midscale(BITS);
  localparam logic [BITS-1:0] MIDSCALE = MID32[BITS-1:0];
  localparam int WCW = (WARM_SMP > 1) ? $clog2(WARM_SMP) : 1;
  localparam int MCW = (MUTE_SMP > 1) ? $clog2(MUTE_SMP) : 1;

  smsdac_state_t   state_reg;
  logic [DIVW-1:0] cnt_reg;
  logic [DIVW-1:0] div_reg;
  logic [WCW-1:0]  wcnt_reg;
  logic [MCW-1:0]  mcnt_reg;
  logic [15:0]     lfsr;
  logic            tick;
  logic            active;
  logic            accept;
  logic            uflow_set;
  logic            unused_lfsr_bits;

  ef_smsdac_lfsr16 u_lfsr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .lfsr  (lfsr)
  );

  // Only the low NR bits feed the switching blocks
  assign unused_lfsr_bits = ^lfsr;

  assign tick      = (state_reg != ST_IDLE) && (cnt_reg == '0);
  assign active    = (state_reg == ST_WARM) || (state_reg == ST_RUN);
  assign o_ready   = tick && active;
  assign accept    = o_ready && i_valid;
  assign uflow_set = o_ready && !i_valid;

  // Sample-period divider: tracks i_div while idle, then counts down and reloads the latched period
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_reg <= '0;
      div_reg <= '0;
    end else if (state_reg == ST_IDLE) begin
      cnt_reg <= i_div;
      div_reg <= i_div;
    end else if (cnt_reg == '0) begin
      cnt_reg <= div_reg;
    end else begin
      cnt_reg <= cnt_reg - DIVW'(1);
    end
  end

  // Phase sequencer; busy is registered alongside the state it decodes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      wcnt_reg  <= '0;
      mcnt_reg  <= '0;
      o_busy    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          wcnt_reg <= '0;
          mcnt_reg <= '0;
          if (i_start) begin
            state_reg <= ST_WARM;
            o_busy    <= 1'b1;
          end
        end
        ST_WARM: begin
          if (tick) begin
            if (!i_start) begin
              state_reg <= ST_MUTE;
              mcnt_reg  <= '0;
            end else if (wcnt_reg == WCW'(WARM_SMP - 1)) begin
              state_reg <= ST_RUN;
            end else begin
              wcnt_reg <= wcnt_reg + WCW'(1);
            end
          end
        end
        ST_RUN: begin
          if (tick && !i_start) begin
            state_reg <= ST_MUTE;
            mcnt_reg  <= '0;
          end
        end
        ST_MUTE: begin
          // i_start is deliberately ignored here: the mute always runs to completion
          if (tick) begin
            if (mcnt_reg == MCW'(MUTE_SMP - 1)) begin
              state_reg <= ST_IDLE;
              o_busy    <= 1'b0;
            end else begin
              mcnt_reg <= mcnt_reg + MCW'(1);
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Encoder-facing registers update only on sample ticks; o_smp flags the update
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_code <= MIDSCALE;
      o_r    <= '0;
      o_en   <= 1'b0;
      o_smp  <= 1'b0;
    end else begin
      o_smp <= tick;
      if (tick) begin
        o_r  <= lfsr[NR-1:0];
        o_en <= (state_reg == ST_RUN) && i_shape_en;
        if (accept) begin
          o_code <= i_code;
        end else if (state_reg == ST_MUTE) begin
          o_code <= MIDSCALE;
        end
      end
    end
  end

  // Sticky underflow flag; a new underflow beats a simultaneous clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_uflow <= 1'b0;
    end else if (uflow_set) begin
      o_uflow <= 1'b1;
    end else if (i_uflow_clr) begin
      o_uflow <= 1'b0;
    end
  end

`ifdef SMSDAC_CTRL_UFLOW_CNT_EN
  // Saturating underflow counter; an underflow during a clear restarts the count at one
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_uflow_cnt <= 8'd0;
    end else if (i_uflow_clr) begin
      o_uflow_cnt <= uflow_set ? 8'd1 : 8'd0;
    end else if (uflow_set && (o_uflow_cnt != 8'd255)) begin
      o_uflow_cnt <= o_uflow_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ef_smsdac_ctrl.sv
// Scoreboard bench for ef_smsdac_ctrl: a sample-level reference model queues expected
// samples; a monitor pops and compares whenever o_smp pulses.
module tb_ef_smsdac_ctrl;

  localparam int BITS     = 8;
  localparam int NR       = 8;
  localparam int DIVW     = 8;
  localparam int WARM_SMP = 4;
  localparam int MUTE_SMP = 4;

  localparam int M_IDLE = 0;
  localparam int M_WARM = 1;
  localparam int M_RUN  = 2;
  localparam int M_MUTE = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [DIVW-1:0] div;
  logic            shape_en;
  logic [BITS-1:0] code;
  logic            valid;
  logic            uflow_clr;
  logic            o_ready;
  logic [BITS-1:0] o_code;
  logic [NR-1:0]   o_r;
  logic            o_en;
  logic            o_smp;
  logic            o_busy;
  logic            o_uflow;
`ifdef SMSDAC_CTRL_UFLOW_CNT_EN
  logic [7:0]      o_uflow_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_mode;
  int          m_clk;
  int          m_n;
  int          m_div;
  int          m_ticks;
  int          m_ucnt;
  logic [15:0] m_lfsr;
  logic [7:0]  m_code;
  logic [7:0]  m_r;
  logic        m_en;
  logic        m_uflow;
  bit          mon_en = 1'b0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  ef_smsdac_ctrl #(
    .BITS(BITS), .NR(NR), .DIVW(DIVW), .WARM_SMP(WARM_SMP), .MUTE_SMP(MUTE_SMP)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_div       (div),
    .i_shape_en  (shape_en),
    .i_code      (code),
    .i_valid     (valid),
    .o_ready     (o_ready),
    .o_code      (o_code),
    .o_r         (o_r),
    .o_en        (o_en),
    .o_smp       (o_smp),
    .o_busy      (o_busy),
    .o_uflow     (o_uflow),
    .i_uflow_clr (uflow_clr)
`ifdef SMSDAC_CTRL_UFLOW_CNT_EN
    ,
    .o_uflow_cnt (o_uflow_cnt)
`endif
  );

  // x^16+x^14+x^13+x^11+1 as the classic right-shift Fibonacci register
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  // Sample ticks fall on the last clock of every (div+1)-clock period after start
  function automatic bit model_tick();
    return (m_mode != M_IDLE) && ((m_clk % (m_div + 1)) == m_div);
  endfunction

  // Reference model, advanced once per clock edge
  always @(posedge clk) begin
    bit          t;
    bit          acc;
    bit          uf;
    logic [15:0] lnow;
    if (rst) begin
      m_mode  = M_IDLE;
      m_clk   = 0;
      m_n     = 0;
      m_div   = 0;
      m_lfsr  = 16'hACE1;
      m_code  = 8'h80;
      m_r     = 8'h00;
      m_en    = 1'b0;
      m_uflow = 1'b0;
      m_ucnt  = 0;
      exp_q.delete();
      mon_en  = 1'b1;
    end else begin
      t      = model_tick();
      lnow   = m_lfsr;
      m_lfsr = lfsr_next(m_lfsr);
      acc    = t && (m_mode == M_WARM || m_mode == M_RUN) && valid;
      uf     = t && (m_mode == M_WARM || m_mode == M_RUN) && !valid;
      if (uf) m_uflow = 1'b1;
      else if (uflow_clr) m_uflow = 1'b0;
      if (uflow_clr) m_ucnt = uf ? 1 : 0;
      else if (uf && m_ucnt < 255) m_ucnt++;
      if (m_mode == M_IDLE) begin
        m_div = div;
        if (start) begin
          m_mode = M_WARM;
          m_clk  = 0;
          m_n    = 0;
        end
      end else begin
        if (t) begin
          if (acc) m_code = code;
          else if (m_mode == M_MUTE) m_code = 8'h80;
          m_r  = lnow[7:0];
          m_en = (m_mode == M_RUN) && shape_en;
          exp_q.push_back({m_code, m_r, m_en});
          m_ticks++;
          case (m_mode)
            M_WARM: begin
              if (!start) begin m_mode = M_MUTE; m_n = 0; end
              else if (m_n == WARM_SMP - 1) m_mode = M_RUN;
              else m_n++;
            end
            M_RUN: begin
              if (!start) begin m_mode = M_MUTE; m_n = 0; end
            end
            default: begin
              if (m_n == MUTE_SMP - 1) m_mode = M_IDLE;
              else m_n++;
            end
          endcase
        end
        m_clk++;
      end
    end
  end

  // Monitor: pop on every o_smp, otherwise check the held outputs and the missing-sample case
  always @(negedge clk) begin
    logic [16:0] e;
    bit          er;
    if (mon_en) begin
      if (o_smp) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL smp_unexpected got code=%h r=%h en=%b want no sample", o_code, o_r, o_en);
        end else begin
          e = exp_q.pop_front();
          if ({o_code, o_r, o_en} !== e) begin
            errors++;
            $display("FAIL sample got code=%h r=%h en=%b want code=%h r=%h en=%b",
                     o_code, o_r, o_en, e[16:9], e[8:1], e[0]);
          end else begin
            $display("sample t=%0t code=%h r=%h en=%b ok", $time, o_code, o_r, o_en);
          end
        end
      end else begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL smp_missing got o_smp=0 want 1 (pending %0d)", exp_q.size());
          exp_q.delete();
        end else if ({o_code, o_r, o_en} !== {m_code, m_r, m_en}) begin
          errors++;
          $display("FAIL held got code=%h r=%h en=%b want code=%h r=%h en=%b",
                   o_code, o_r, o_en, m_code, m_r, m_en);
        end
      end
      er = model_tick() && (m_mode == M_WARM || m_mode == M_RUN);
      checks++;
      if (o_ready !== er) begin
        errors++;
        $display("FAIL ready got %b want %b", o_ready, er);
      end
      checks++;
      if (o_busy !== (m_mode != M_IDLE)) begin
        errors++;
        $display("FAIL busy got %b want %b", o_busy, (m_mode != M_IDLE));
      end
      checks++;
      if (o_uflow !== m_uflow) begin
        errors++;
        $display("FAIL uflow got %b want %b", o_uflow, m_uflow);
      end
`ifdef SMSDAC_CTRL_UFLOW_CNT_EN
      checks++;
      if (o_uflow_cnt !== m_ucnt[7:0]) begin
        errors++;
        $display("FAIL uflow_cnt got %0d want %0d", o_uflow_cnt, m_ucnt);
      end
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      code = BITS'($urandom);
    end
  endtask

  task automatic wait_mode(input int m, input int lim, input string nm);
    int k;
    k = 0;
    while (m_mode != m && k < lim) begin
      cyc(1);
      k++;
    end
    if (m_mode != m) begin
      checks++;
      errors++;
      $display("FAIL %s timeout mode=%0d want %0d", nm, m_mode, m);
    end
  endtask

  task automatic wait_ticks(input int n, input int lim);
    int k;
    int t0;
    k  = 0;
    t0 = m_ticks;
    while (m_ticks < t0 + n && k < lim) begin
      cyc(1);
      k++;
    end
    if (m_ticks < t0 + n) begin
      checks++;
      errors++;
      $display("FAIL wait_ticks timeout got %0d want %0d", m_ticks - t0, n);
    end
  endtask

  task automatic wait_next_tick(input int lim);
    int k;
    k = 0;
    while (!model_tick() && k < lim) begin
      cyc(1);
      k++;
    end
    if (!model_tick()) begin
      checks++;
      errors++;
      $display("FAIL wait_next_tick timeout got no tick want tick");
    end
  endtask

  task automatic chk_reset_values(input string nm);
    chk({nm, "_code"}, 32'(o_code), 32'h80);
    chk({nm, "_r"}, 32'(o_r), 32'h0);
    chk({nm, "_en"}, 32'(o_en), 32'h0);
    chk({nm, "_smp"}, 32'(o_smp), 32'h0);
    chk({nm, "_busy"}, 32'(o_busy), 32'h0);
    chk({nm, "_uflow"}, 32'(o_uflow), 32'h0);
  endtask

  initial begin
    m_ticks   = 0;
    rst       = 1'b1;
    start     = 1'b0;
    div       = 8'd3;
    shape_en  = 1'b1;
    code      = 8'h00;
    valid     = 1'b1;
    uflow_clr = 1'b0;
    cyc(1);
    chk_reset_values("reset");
    rst = 1'b0;
    cyc(10);

    // Warm-up then shaping with a 4-clock sample period
    div   = 8'd3;
    start = 1'b1;
    wait_mode(M_RUN, 100, "enter_run");
    cyc(12);
    chk("en_in_run", 32'(o_en), 32'h1);

    // Two missed samples set the sticky flag
    valid = 1'b0;
    wait_ticks(2, 50);
    valid = 1'b1;
    chk("uflow_set", 32'(o_uflow), 32'h1);
`ifdef SMSDAC_CTRL_UFLOW_CNT_EN
    chk("uflow_cnt2", 32'(o_uflow_cnt), 32'd2);
`endif
    // Clear coinciding with an underflow: set wins
    wait_next_tick(20);
    valid     = 1'b0;
    uflow_clr = 1'b1;
    cyc(1);
    valid     = 1'b1;
    uflow_clr = 1'b0;
    chk("uflow_set_wins", 32'(o_uflow), 32'h1);
`ifdef SMSDAC_CTRL_UFLOW_CNT_EN
    chk("uflow_cnt_restart", 32'(o_uflow_cnt), 32'd1);
`endif
    uflow_clr = 1'b1;
    cyc(1);
    uflow_clr = 1'b0;
    chk("uflow_cleared", 32'(o_uflow), 32'h0);

    // Randomized traffic in RUN
    repeat (60) begin
      cyc(1);
      valid     = ($urandom_range(0, 3) != 0);
      shape_en  = 1'($urandom);
      uflow_clr = ($urandom_range(0, 7) == 0);
    end
    valid     = 1'b1;
    uflow_clr = 1'b0;
    shape_en  = 1'b1;

    // Stop: mute runs to completion even with start reasserted, then warm-up restarts
    start = 1'b0;
    wait_mode(M_MUTE, 50, "enter_mute");
    cyc(3);
    start = 1'b1;
    wait_mode(M_IDLE, 50, "mute_to_idle");
    chk("busy_after_mute", 32'(o_busy), 32'h0);
    chk("code_after_mute", 32'(o_code), 32'h80);
    wait_mode(M_WARM, 5, "restart_warm");
    chk("busy_restart", 32'(o_busy), 32'h1);

    // Divide-by-one: a sample every clock; later i_div change is ignored
    start = 1'b0;
    wait_mode(M_IDLE, 100, "idle_for_div0");
    div   = 8'd0;
    start = 1'b1;
    wait_mode(M_RUN, 50, "run_div0");
    cyc(5);
    chk("smp_div0", 32'(o_smp), 32'h1);
    div = 8'd7;
    repeat (20) begin
      cyc(1);
      valid = ($urandom_range(0, 4) != 0);
    end
    valid = 1'b1;

    // Reset in the middle of RUN
    rst = 1'b1;
    cyc(1);
    chk_reset_values("rst_mid_run");
    rst = 1'b0;

    // Random period restart
    div   = DIVW'($urandom_range(0, 5));
    start = 1'b1;
    repeat (80) begin
      cyc(1);
      valid    = ($urandom_range(0, 3) != 0);
      shape_en = 1'($urandom);
    end
    start = 1'b0;
    wait_mode(M_IDLE, 200, "final_idle");
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ef_smsdac_ctrl.md
Name: ef_smsdac_ctrl

Overview:
- Sample-rate controller and scheduler for the segmented mismatch-shaping DAC encoder.
- Generates the sample strobe from a programmable clock divider and accepts input codes through a valid/ready handshake.
- Supplies the encoder's shaping-enable and per-switching-block dither bits from an on-chip LFSR.
- Sequences start-up warm-up (whitening) → mismatch shaping → midscale mute → idle; sits between the sample source and the encoder's input retiming register.

Parameters:
BITS, 8, DAC code width
NR, 8, number of dither bits driven to switching blocks (1..16)
DIVW, 8, divider width
WARM_SMP, 16, samples in warm-up (whitening) phase, ≥1
MUTE_SMP, 4, midscale samples before returning to idle, ≥1

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  level; 1 = run converter
i_div  in  DIVW  sample period = i_div+1 clocks; sampled only in IDLE
i_shape_en  in  1  1 = mismatch shaping in RUN, 0 = static/whitened
i_code  in  BITS  input sample
i_valid  in  1  i_code valid
o_ready  out  1  sample accepted this cycle if i_valid
o_code  out  BITS  code to encoder
o_r  out  NR  dither bits to switching-block state machines
o_en  out  1  shaping enable to switching blocks
o_smp  out  1  one-cycle pulse: o_code/o_r/o_en just updated
o_busy  out  1  state != IDLE
o_uflow  out  1  sticky underflow flag
i_uflow_clr  in  1  clears o_uflow

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: state IDLE, cnt 0, o_code = midscale (1<<(BITS-1), 8'h80), o_r 0, o_en 0, o_smp 0, o_uflow 0, LFSR 16'hACE1.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Advances every clock in all states and is never all-zero.
- Divider: in IDLE, cnt <= i_div. Otherwise cnt decrements; tick = (state != IDLE) && cnt==0; on tick, cnt reloads the latched div. i_div=0 gives a tick every clock.
- o_ready = tick && state ∈ {WARM, RUN}. Combinational. Accept = o_ready && i_valid.
- On every tick edge:
  - o_r <= lfsr[NR-1:0]; o_smp <= 1 next cycle, otherwise 0.
  - o_code <= i_code if accepted; else held value in WARM/RUN; midscale in MUTE.
  - o_en <= i_shape_en in RUN, 0 otherwise.
- Latency: accepted code appears on o_code one cycle after the accept, coincident with o_smp.
- State machine. Transitions are evaluated only on tick, except IDLE.
  - IDLE: i_start=1 → WARM next cycle. wcnt=0, div latched.
  - WARM: tick with i_start=0 → MUTE. Tick with wcnt==WARM_SMP-1 → RUN. Else wcnt++. o_en forced 0 (whitened, i_r routed).
  - RUN: tick with i_start=0 → MUTE.
  - MUTE: o_ready=0, o_en=0, o_code=midscale. After MUTE_SMP ticks → IDLE.
- Boundary conditions:
  - i_start reasserted during MUTE is ignored until IDLE is reached; restart happens the cycle after IDLE if i_start is still 1.
  - Underflow: tick in WARM/RUN without i_valid → o_code held and o_uflow <= 1.
  - i_uflow_clr clears o_uflow. Simultaneous set and clear: set wins.
  - i_div changes outside IDLE have no effect.
  - i_rst mid-operation: immediate return to reset values at the next edge, including o_code=midscale.
- o_busy is registered state decode.

Optional Feature:
- Macro SMSDAC_CTRL_UFLOW_CNT_EN.
- Defined: adds output o_uflow_cnt [7:0], a saturating count of underflow ticks (stops at 255). It is cleared by i_rst and by i_uflow_clr; if an underflow coincides with a clear, the count becomes 1.
- Undefined: no port and no counter; the o_uflow flag only.

Decomposition:
- Shared package ef_smsdac_pkg holds:
  - state enum (IDLE, WARM, RUN, MUTE)
  - LFSR seed 16'hACE1 and tap mask
  - midscale constant function of BITS
- One sub-module: ef_smsdac_lfsr16 (free-running LFSR, seed on reset, 16-bit state out).
- Divider, FSM and output registers stay in ef_smsdac_ctrl.

Test Plan:
- Reset then idle with i_start=0 → o_code=8'h80, o_en=0, o_busy=0, o_smp never pulses; LFSR sequence from 16'hACE1 matches the reference model.
- i_div=3, WARM_SMP=4, i_start=1, i_valid=1, i_shape_en=1, codes 1,2,3,… → o_ready once every 4 clocks; o_code follows 1 cycle after accept with o_smp; o_en=0 for the first 4 samples, then 1.
- In RUN, drop i_valid for 2 ticks → o_code holds its last value and o_uflow=1. With the feature macro, o_uflow_cnt=2. Assert i_uflow_clr on the same cycle as an underflow → o_uflow stays 1.
- In RUN, drop i_start → next tick enters MUTE: o_code=8'h80 for MUTE_SMP=4 samples, o_ready=0, then IDLE with o_busy=0. Reassert i_start during MUTE → mute completes, then WARM restarts.
- i_div=0 → a tick and o_smp every clock. Change i_div to 7 while in RUN → period unchanged.
- Assert i_rst mid-RUN → next cycle all outputs at reset values, including LFSR=16'hACE1.
